// File: rtl/iter_muldiv_if.sv
// Start/busy/done handshake and operand/result bus of the iterative multiply/divide unit.
// The requester uses the master modport and the arithmetic unit uses the slave modport.
interface iter_muldiv_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/iter_muldiv.sv
// Multi-cycle unsigned multiply/divide unit: one shift-add or restoring-divide step per clock.
// The result is registered on entry to DONE and held until the next operation completes.
module iter_muldiv #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  iter_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   operand_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               dbz_reg;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   result_next;

  // One datapath step; the multiplier sits in the low half of prod_reg and shifts out LSB first.
  always_comb begin
    mul_sum     = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                + (prod_reg[0] ? {1'b0, operand_reg} : {(WIDTH+1){1'b0}});
    prod_next   = {mul_sum, prod_reg[WIDTH-1:1]};
    div_shift   = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    div_trial   = {1'b0, div_shift} - {2'b00, operand_reg};
    rem_next    = div_shift;
    quo_next    = {quo_reg[WIDTH-2:0], 1'b0};
    if (!div_trial[WIDTH+1]) begin
      rem_next = div_trial[WIDTH:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end
    case (op_reg)
      2'b00:   result_next = prod_next[WIDTH-1:0];
      2'b01:   result_next = prod_next[2*WIDTH-1:WIDTH];
      2'b10:   result_next = quo_next;
      default: result_next = rem_next[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= '0;
      operand_reg <= '0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      dbz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (op_reg[1]) begin
            rem_reg <= rem_next;
            quo_reg <= quo_next;
          end else begin
            prod_reg <= prod_next;
          end
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            result_reg <= result_next;
          end
        end
        default: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg  <= bus.op;
            cnt_reg <= '0;
            dbz_reg <= 1'b0;
            // Division by zero completes immediately without iterating.
            if (bus.op[1] && (bus.b == '0)) begin
              result_reg <= bus.op[0] ? bus.a : {WIDTH{1'b1}};
              dbz_reg    <= 1'b1;
              done_reg   <= 1'b1;
              state_reg  <= DONE;
            end else begin
              operand_reg <= bus.op[1] ? bus.b : bus.a;
              prod_reg    <= {{WIDTH{1'b0}}, bus.b};
              rem_reg     <= '0;
              quo_reg     <= bus.a;
              busy_reg    <= 1'b1;
              state_reg   <= RUN;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.result      = result_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: directed scenarios plus randomized ops against an arithmetic model.
module tb_iter_muldiv;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iter_muldiv_if #(.WIDTH(W)) bus ();
  iter_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [W-1:0] b);
    return (op[1] && b == 0) ? 1 : W + 1;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge, operands scrambled.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  task automatic wait_done(input int c0, output int cycles, output bit timed_out);
    cycles = c0;
    while (!bus.done && cycles < 64) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = !bus.done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.div_by_zero} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h dbz=%b, required 0 0 0000 0",
               bus.busy, bus.done, bus.result, bus.div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset: busy=%b done=%b result=%h dbz=%b", bus.busy, bus.done, bus.result, bus.div_by_zero);
  endtask

  // Directed table covering mul/div cases; each op starts from IDLE.
  task automatic test_directed;
    logic [1:0]   ops [6] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
    logic [W-1:0] as  [6] = '{16'd3, 16'hFFFF, 16'hFFFF, 16'd100, 16'h1234, 16'h1234};
    logic [W-1:0] bs  [6] = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd7, 16'd0, 16'd0};
    logic [W-1:0] exp_res [6] = '{16'h000F, 16'hFFFE, 16'h0001, 16'd14, 16'hFFFF, 16'h1234};
    int cycles;
    bit to;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], as[i], bs[i]);
      if (model_latency(ops[i], bs[i]) > 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_run[%0d]: busy=%b, required 1", i, bus.busy);
        end
      end
      wait_done(1, cycles, to);
      $display("directed op=%0d a=%h b=%h result=%h dbz=%b cycles=%0d",
               ops[i], as[i], bs[i], bus.result, bus.div_by_zero, cycles);
      checks++;
      if (to || cycles !== model_latency(ops[i], bs[i])) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d (timeout=%b), required %0d",
                 i, cycles, to, model_latency(ops[i], bs[i]));
      end
      checks++;
      if (bus.result !== exp_res[i] || bus.result !== model_result(ops[i], as[i], bs[i])) begin
        errors++;
        $display("FAIL result[%0d]: got %h, required %h", i, bus.result, exp_res[i]);
      end
      checks++;
      if (bus.div_by_zero !== (ops[i][1] && bs[i] == 0)) begin
        errors++;
        $display("FAIL dbz[%0d]: got %b, required %b", i, bus.div_by_zero, ops[i][1] && bs[i] == 0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_res[i]) begin
        errors++;
        $display("FAIL hold[%0d]: done=%b busy=%b result=%h, required 0 0 %h",
                 i, bus.done, bus.busy, bus.result, exp_res[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cycles;
    bit to;
    start_op(2'd2, 16'd100, 16'd7);
    wait_done(1, cycles, to);
    checks++;
    if (to || bus.result !== 16'd14) begin
      errors++;
      $display("FAIL b2b_first: result=%h timeout=%b, required 000e", bus.result, to);
    end
    start_op(2'd3, 16'd100, 16'd7);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", bus.done, bus.busy);
    end
    wait_done(1, cycles, to);
    $display("back_to_back MOD result=%h cycles=%0d", bus.result, cycles);
    checks++;
    if (to || cycles !== W + 1 || bus.result !== 16'd2) begin
      errors++;
      $display("FAIL b2b_second: result=%h cycles=%0d, required 0002 in %0d", bus.result, cycles, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int cycles;
    bit to;
    start_op(2'd0, 16'd300, 16'd7);
    repeat (4) @(negedge clk);
    start_op(2'd2, 16'd9, 16'd0);
    wait_done(6, cycles, to);
    $display("start_in_run result=%h cycles=%0d dbz=%b", bus.result, cycles, bus.div_by_zero);
    checks++;
    if (to || cycles !== W + 1 || bus.result !== 16'd2100 || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: result=%h cycles=%0d dbz=%b, required %h %0d 0",
               bus.result, cycles, bus.div_by_zero, 16'd2100, W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int cycles;
    bit seen_done;
    bit to;
    start_op(2'd1, 16'hABCD, 16'h1234);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.div_by_zero} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b result=%h dbz=%b, required 0 0 0000 0",
               bus.busy, bus.done, bus.result, bus.div_by_zero);
    end
    seen_done = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: activity seen=%b, required 0", seen_done);
    end
    start_op(2'd0, 16'd2, 16'd2);
    wait_done(1, cycles, to);
    $display("after_abort MULLO 2*2 result=%h cycles=%0d", bus.result, cycles);
    checks++;
    if (to || bus.result !== 16'd4) begin
      errors++;
      $display("FAIL after_abort: result=%h timeout=%b, required 0004", bus.result, to);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int cycles;
    bit to;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = W'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? 16'd0 : W'($urandom >> $urandom_range(0, 15));
      start_op(op, a, b);
      wait_done(1, cycles, to);
      $display("random[%0d] op=%0d a=%h b=%h result=%h dbz=%b cycles=%0d",
               i, op, a, b, bus.result, bus.div_by_zero, cycles);
      checks++;
      if (to || cycles !== model_latency(op, b) || bus.result !== model_result(op, a, b)
          || bus.div_by_zero !== (op[1] && b == 0)) begin
        errors++;
        $display("FAIL random[%0d]: result=%h dbz=%b cycles=%0d, required %h %b %0d",
                 i, bus.result, bus.div_by_zero, cycles, model_result(op, a, b),
                 op[1] && b == 0, model_latency(op, b));
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
